mac_operand_feeder: RTL

Transmit-side sequencer for the serial MAC neurons (`neuron_inputlayer` and siblings). It buffers one input vector and one weight vector, then streams (data, weight, index) beats to a neuron under a valid/ready handshake. It replaces the free-running `counter` as the source of per-cycle operands. At the end of each vector it signals completion with a one-cycle `done` pulse.

---
 rtl/mlp_pkg.sv | 27 ++
 rtl/operand_buffer.sv | 58 +++++
 rtl/mac_operand_feeder.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/mlp_pkg.sv
// Shared types and default widths for the MLP neuron datapath and its
// operand feeder.
package mlp_pkg;

    localparam int NEURON_WIDTH_DEFAULT = 10;
    localparam int NEURON_BITS_DEFAULT  = 15;
    localparam int W_BITS_DEFAULT       = 32;
    localparam int B_BITS_DEFAULT       = 15;

    // Feeder sequencing states.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        BIAS   = 2'd2,
        DONE   = 2'd3
    } feeder_state_e;

    // One operand beat as seen by a neuron at the default widths.
    typedef struct packed {
        logic signed [NEURON_BITS_DEFAULT:0]  data;
        logic signed [W_BITS_DEFAULT-1:0]     weight;
        logic        [31:0]                   index;
        logic                                 last;
        logic                                 is_bias;
    } op_beat_t;

endpackage

// File: rtl/operand_buffer.sv
// Two-bank operand register file: bank 0 holds input data, bank 1 holds
// weights. Synchronous clear, one write port, one combinational read port
// that returns both banks at the same element index.
module operand_buffer
    import mlp_pkg::*;
#(
    parameter int DEPTH = NEURON_WIDTH_DEFAULT,
    parameter int AW    = 4,
    parameter int DW    = NEURON_BITS_DEFAULT + 1,
    parameter int WW    = W_BITS_DEFAULT
) (
    input  logic                 clk,
    input  logic                 i_clr,
    input  logic                 i_wr_en,
    input  logic                 i_wr_sel,
    input  logic [AW-1:0]        i_wr_addr,
    input  logic [WW-1:0]        i_wr_data,
    input  logic [AW-1:0]        i_rd_addr,
    output logic signed [DW-1:0] o_rd_data,
    output logic signed [WW-1:0] o_rd_weight
);

    logic signed [DW-1:0] r_dbank [DEPTH];
    logic signed [WW-1:0] r_wbank [DEPTH];

    logic w_wr_ok;
    logic w_rd_ok;

    assign w_wr_ok = (32'(i_wr_addr) < DEPTH);
    assign w_rd_ok = (32'(i_rd_addr) < DEPTH);

    // Bank storage: clear wins over write; out-of-range writes are dropped.
    always_ff @(posedge clk) begin
        if (i_clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_dbank[i] <= '0;
                r_wbank[i] <= '0;
            end
        end else if (i_wr_en && w_wr_ok) begin
            if (i_wr_sel) begin
                r_wbank[i_wr_addr] <= i_wr_data;
            end else begin
                r_dbank[i_wr_addr] <= i_wr_data[DW-1:0];
            end
        end
    end

    // Indexed read of both banks; addresses past the end read as zero.
    always_comb begin
        o_rd_data   = '0;
        o_rd_weight = '0;
        if (w_rd_ok) begin
            o_rd_data   = r_dbank[i_rd_addr];
            o_rd_weight = r_wbank[i_rd_addr];
        end
    end

endmodule

// File: rtl/mac_operand_feeder.sv
// Transmit-side operand sequencer for the serial MAC neurons. Buffers one
// data vector and one weight vector, then streams (data, weight, index)
// beats under valid/ready and pulses done once the vector is consumed.
// Build option: define MAC_FEEDER_BIAS_BEAT_EN to append a bias beat
// (data = bias, weight = 1) so the consumer accumulates the bias through
// its MAC; leave it undefined when the consumer adds the bias itself.
module mac_operand_feeder
    import mlp_pkg::*;
#(
    parameter int NEURON_WIDTH = NEURON_WIDTH_DEFAULT,
    parameter int NEURON_BITS  = NEURON_BITS_DEFAULT,
    parameter int W_BITS       = W_BITS_DEFAULT,
    parameter int B_BITS       = B_BITS_DEFAULT
) (
    input  logic                              clk,
    input  logic                              rstn,
    input  logic                              wr_en,
    input  logic                              wr_sel,
    input  logic [$clog2(NEURON_WIDTH)-1:0]   wr_addr,
    input  logic [W_BITS-1:0]                 wr_data,
    input  logic [B_BITS:0]                   bias_in,
    input  logic                              start,
    output logic                              busy,
    output logic                              op_valid,
    input  logic                              op_ready,
    output logic signed [NEURON_BITS:0]       op_data,
    output logic signed [W_BITS-1:0]          op_weight,
    output logic [31:0]                       op_index,
    output logic                              op_last,
    output logic                              op_is_bias,
    output logic                              done
);

    localparam int              AW       = $clog2(NEURON_WIDTH);
    localparam int              NB       = NEURON_BITS + 1;
    localparam logic [AW-1:0]   LAST_IDX = AW'(NEURON_WIDTH - 1);

`ifdef MAC_FEEDER_BIAS_BEAT_EN
    // The final beat is the bias beat, never a vector element.
    localparam logic LAST_ON_ELEM = 1'b0;
    localparam logic signed [W_BITS-1:0] W_ONE = W_BITS'(1);

    // Bias is narrowed or sign-extended onto the data lane.
    function automatic logic signed [NEURON_BITS:0] bias_to_data(
        input logic signed [B_BITS:0] b
    );
        return NB'(b);
    endfunction
`else
    localparam logic LAST_ON_ELEM = 1'b1;
`endif

    feeder_state_e               r_state;
    logic [AW-1:0]               r_idx;
    logic                        r_busy;
    logic                        r_op_valid;
    logic signed [NEURON_BITS:0] r_op_data;
    logic signed [W_BITS-1:0]    r_op_weight;
    logic [31:0]                 r_op_index;
    logic                        r_op_last;
    logic                        r_op_is_bias;
    logic                        r_done;

`ifdef MAC_FEEDER_BIAS_BEAT_EN
    logic signed [B_BITS:0]      r_bias;
`else
    // Bias is consumed directly by the neuron in this build.
    logic                        w_unused_bias;
    assign w_unused_bias = ^bias_in;
`endif

    logic [AW-1:0]               w_idx_nxt;
    logic [AW-1:0]               w_rd_addr;
    logic                        w_buf_wr;
    logic                        w_fwd;
    logic signed [NEURON_BITS:0] w_buf_data;
    logic signed [W_BITS-1:0]    w_buf_weight;
    logic signed [NEURON_BITS:0] w_rd_data;
    logic signed [W_BITS-1:0]    w_rd_weight;
    logic                        w_start_acc;
    logic                        w_xfer;

    assign w_idx_nxt = r_idx + AW'(1);

    // In IDLE the next beat to load is element 0; while streaming it is idx+1.
    assign w_rd_addr = (r_state == STREAM) ? w_idx_nxt : '0;

    // Buffers are writable only while idle, so they stay frozen during a stream.
    assign w_buf_wr = wr_en && (r_state == IDLE);

    // A write landing on the element being loaded this edge must be seen by
    // that load, so a same-cycle start/write streams the new value.
    assign w_fwd = w_buf_wr && (wr_addr == w_rd_addr);

    assign w_rd_data   = (w_fwd && !wr_sel) ? wr_data[NEURON_BITS:0] : w_buf_data;
    assign w_rd_weight = (w_fwd &&  wr_sel) ? wr_data                : w_buf_weight;

    // Start is refused while busy and in the cycle the done pulse is out.
    assign w_start_acc = start && (r_state == IDLE) && !r_done;
    assign w_xfer      = r_op_valid && op_ready;

    operand_buffer #(
        .DEPTH (NEURON_WIDTH),
        .AW    (AW),
        .DW    (NB),
        .WW    (W_BITS)
    ) u_buf (
        .clk         (clk),
        .i_clr       (!rstn),
        .i_wr_en     (w_buf_wr),
        .i_wr_sel    (wr_sel),
        .i_wr_addr   (wr_addr),
        .i_wr_data   (wr_data),
        .i_rd_addr   (w_rd_addr),
        .o_rd_data   (w_buf_data),
        .o_rd_weight (w_buf_weight)
    );

    // Sequencer FSM with registered beat outputs; outputs hold while stalled.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state      <= IDLE;
            r_idx        <= '0;
            r_busy       <= 1'b0;
            r_op_valid   <= 1'b0;
            r_op_data    <= '0;
            r_op_weight  <= '0;
            r_op_index   <= '0;
            r_op_last    <= 1'b0;
            r_op_is_bias <= 1'b0;
            r_done       <= 1'b0;
`ifdef MAC_FEEDER_BIAS_BEAT_EN
            r_bias       <= '0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_start_acc) begin
`ifdef MAC_FEEDER_BIAS_BEAT_EN
                        r_bias       <= bias_in;
`endif
                        r_idx        <= '0;
                        r_busy       <= 1'b1;
                        r_op_valid   <= 1'b1;
                        r_op_data    <= w_rd_data;
                        r_op_weight  <= w_rd_weight;
                        r_op_index   <= '0;
                        r_op_last    <= LAST_ON_ELEM && (NEURON_WIDTH == 1);
                        r_op_is_bias <= 1'b0;
                        r_state      <= STREAM;
                    end
                end
                STREAM: begin
                    if (w_xfer) begin
                        if (r_idx == LAST_IDX) begin
`ifdef MAC_FEEDER_BIAS_BEAT_EN
                            r_op_data    <= bias_to_data(r_bias);
                            r_op_weight  <= W_ONE;
                            r_op_index   <= 32'(NEURON_WIDTH);
                            r_op_last    <= 1'b1;
                            r_op_is_bias <= 1'b1;
                            r_state      <= BIAS;
`else
                            r_op_valid   <= 1'b0;
                            r_op_data    <= '0;
                            r_op_weight  <= '0;
                            r_op_index   <= '0;
                            r_op_last    <= 1'b0;
                            r_op_is_bias <= 1'b0;
                            r_state      <= DONE;
`endif
                        end else begin
                            r_idx        <= w_idx_nxt;
                            r_op_data    <= w_rd_data;
                            r_op_weight  <= w_rd_weight;
                            r_op_index   <= 32'(w_idx_nxt);
                            r_op_last    <= LAST_ON_ELEM && (w_idx_nxt == LAST_IDX);
                        end
                    end
                end
                BIAS: begin
                    if (w_xfer) begin
                        r_op_valid   <= 1'b0;
                        r_op_data    <= '0;
                        r_op_weight  <= '0;
                        r_op_index   <= '0;
                        r_op_last    <= 1'b0;
                        r_op_is_bias <= 1'b0;
                        r_state      <= DONE;
                    end
                end
                DONE: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_idx   <= '0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy       = r_busy;
    assign op_valid   = r_op_valid;
    assign op_data    = r_op_data;
    assign op_weight  = r_op_weight;
    assign op_index   = r_op_index;
    assign op_last    = r_op_last;
    assign op_is_bias = r_op_is_bias;
    assign done       = r_done;

endmodule
